// File: rtl/seven_segment_scanner_if.sv
// Load port of the seven-segment scanner: one display image per valid/ready transfer.
interface seven_segment_scanner_if;
  logic [15:0] loadValue;
  logic [3:0]  loadDp;
  logic [3:0]  loadMask;
  logic        loadValid;
  logic        loadReady;

  modport master (output loadValue, loadDp, loadMask, loadValid, input loadReady);
  modport slave  (input loadValue, loadDp, loadMask, loadValid, output loadReady);
endinterface

// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment driver with per-slot blanking and
// frame-aligned double buffering of the displayed value.
module seven_segment_scanner #(
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter int unsigned BLANK_CYCLES   = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                   clock,
  input  logic                   resetN,
  seven_segment_scanner_if.slave load,
  output logic                   frameStart,
  output logic [7:0]             sevenSegmentData,
  output logic [3:0]             sevenSegmentEnable
);
  localparam int unsigned      CNT_W     = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [7:0]       SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  if (REFRESH_DIV < 2 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
    $error("seven_segment_scanner: need REFRESH_DIV >= 2 and BLANK_CYCLES < REFRESH_DIV");
  end

  function automatic logic [6:0] hex7seg(input logic [3:0] nib);
    logic [6:0] seg;
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]       digit_q, digit_d;
  logic [15:0]      act_value_q, act_value_d, pend_value_q, pend_value_d;
  logic [3:0]       act_dp_q, act_dp_d, act_mask_q, act_mask_d;
  logic [3:0]       pend_dp_q, pend_dp_d, pend_mask_q, pend_mask_d;
  logic             pend_empty_q, pend_empty_d;
  logic             started_q, started_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       seg_q, seg_d;
  logic [3:0]       en_q, en_d;
  logic             slot_end, frame_end, accept, blank;
  logic [3:0]       nibble;

  // Scan counters, pending/active image swap at the frame boundary, and output decode.
  always_comb begin
    slot_end      = (slot_cnt_q == SLOT_LAST);
    frame_end     = slot_end && (digit_q == 2'd3);
    accept        = load.loadValid && pend_empty_q;
    blank         = (slot_cnt_q < BLANK_END);
    nibble        = 4'(act_value_q >> {digit_q, 2'b00});

    slot_cnt_d    = slot_end ? '0 : slot_cnt_q + CNT_W'(1);
    digit_d       = slot_end ? digit_q + 2'd1 : digit_q;
    act_value_d   = act_value_q;
    act_dp_d      = act_dp_q;
    act_mask_d    = act_mask_q;
    pend_value_d  = pend_value_q;
    pend_dp_d     = pend_dp_q;
    pend_mask_d   = pend_mask_q;
    pend_empty_d  = pend_empty_q;
    started_d     = 1'b1;
    frame_start_d = frame_end || !started_q;
    en_d          = 4'b0000;
    seg_d         = SEG_OFF;

    if (frame_end && !pend_empty_q) begin
      act_value_d  = pend_value_q;
      act_dp_d     = pend_dp_q;
      act_mask_d   = pend_mask_q;
      pend_value_d = '0;
      pend_dp_d    = '0;
      pend_mask_d  = '0;
      pend_empty_d = 1'b1;
    end

    // accept implies pending is empty, so it never collides with the swap above
    if (accept) begin
      pend_value_d = load.loadValue;
      pend_dp_d    = load.loadDp;
      pend_mask_d  = load.loadMask;
      pend_empty_d = 1'b0;
    end

    if (!blank) begin
      en_d  = (4'b0001 << digit_q) & act_mask_q;
      seg_d = {act_dp_q[digit_q], hex7seg(nibble)} ^ SEG_OFF;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      slot_cnt_q    <= '0;
      digit_q       <= '0;
      act_value_q   <= '0;
      act_dp_q      <= '0;
      act_mask_q    <= '0;
      pend_value_q  <= '0;
      pend_dp_q     <= '0;
      pend_mask_q   <= '0;
      pend_empty_q  <= 1'b1;
      started_q     <= 1'b0;
      frame_start_q <= 1'b0;
      en_q          <= '0;
      seg_q         <= SEG_OFF;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_q       <= digit_d;
      act_value_q   <= act_value_d;
      act_dp_q      <= act_dp_d;
      act_mask_q    <= act_mask_d;
      pend_value_q  <= pend_value_d;
      pend_dp_q     <= pend_dp_d;
      pend_mask_q   <= pend_mask_d;
      pend_empty_q  <= pend_empty_d;
      started_q     <= started_d;
      frame_start_q <= frame_start_d;
      en_q          <= en_d;
      seg_q         <= seg_d;
    end
  end

  assign load.loadReady      = pend_empty_q;
  assign frameStart          = frame_start_q;
  assign sevenSegmentData    = seg_q;
  assign sevenSegmentEnable  = en_q;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: active-high and active-low instances driven in
// lockstep, checked against a model indexed by absolute cycle count since reset release.
module tb_seven_segment_scanner;
  localparam int unsigned R     = 8;
  localparam int unsigned B     = 2;
  localparam int unsigned FRAME = 4 * R;
  localparam logic [7:0] SEG_TAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  typedef struct packed { logic [15:0] v; logic [3:0] dp; logic [3:0] m; } ld_t;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  seven_segment_scanner_if lda();
  seven_segment_scanner_if ldb();
  logic       fsA, fsB;
  logic [7:0] dA, dB;
  logic [3:0] eA, eB;

  seven_segment_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .SEG_ACTIVE_LOW(1'b0)) dut_a (
    .clock(clock), .resetN(resetN), .load(lda), .frameStart(fsA),
    .sevenSegmentData(dA), .sevenSegmentEnable(eA));
  seven_segment_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .SEG_ACTIVE_LOW(1'b1)) dut_b (
    .clock(clock), .resetN(resetN), .load(ldb), .frameStart(fsB),
    .sevenSegmentData(dB), .sevenSegmentEnable(eB));

  int errors = 0;
  int checks = 0;
  ld_t ldq[$];
  bit  fire = 1'b0;

  // Reference state: cycles since release, active/pending images, expected outputs.
  int         m_t;
  bit         m_pfull;
  ld_t        m_act, m_pend;
  logic [3:0] m_en;
  logic [7:0] m_data;
  logic       m_fs, m_ready;

  task automatic model_reset();
    m_t = 0; m_pfull = 1'b0; m_act = '0; m_pend = '0;
    m_en = 4'b0; m_data = 8'h00; m_fs = 1'b0; m_ready = 1'b1;
  endtask

  task automatic model_step();
    int slot, dig;
    bit boundary, acc;
    slot = m_t % R;
    dig  = (m_t / R) % 4;
    boundary = (m_t % FRAME) == FRAME - 1;
    if (slot < B) begin
      m_en = 4'b0; m_data = 8'h00;
    end else begin
      m_en   = m_act.m[dig] ? 4'(1 << dig) : 4'b0;
      m_data = SEG_TAB[m_act.v[dig*4 +: 4]] | (m_act.dp[dig] ? 8'h80 : 8'h00);
    end
    m_fs = (m_t == 0) || boundary;
    acc  = lda.loadValid && !m_pfull;
    if (boundary && m_pfull) begin m_act = m_pend; m_pfull = 1'b0; end
    if (acc) begin m_pend = {lda.loadValue, lda.loadDp, lda.loadMask}; m_pfull = 1'b1; end
    m_ready = !m_pfull;
    m_t++;
  endtask

  task automatic drive_load(input ld_t x, input logic vld);
    lda.loadValue = x.v; lda.loadDp = x.dp; lda.loadMask = x.m; lda.loadValid = vld;
    ldb.loadValue = x.v; ldb.loadDp = x.dp; ldb.loadMask = x.m; ldb.loadValid = vld;
  endtask

  // One clock: advance the model on the rising edge, update the load driver on the falling edge.
  task automatic tick();
    @(posedge clock);
    if (!resetN) model_reset(); else model_step();
    @(negedge clock);
    if (fire) begin drive_load('0, 1'b0); ldq.delete(0); fire = 1'b0; end
    if (!lda.loadValid && ldq.size() > 0) drive_load(ldq[0], 1'b1);
    fire = lda.loadValid && lda.loadReady;
  endtask

  task automatic wait_applied(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      tick();
      if (fsA && lda.loadReady && !lda.loadValid && ldq.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (eA !== 4'b0 || eB !== 4'b0) begin errors++; $display("FAIL reset_enable got=%b/%b exp=0000", eA, eB); end
      checks++; if (dA !== 8'h00 || dB !== 8'hFF) begin errors++; $display("FAIL reset_data got=%h/%h exp=00/ff", dA, dB); end
      checks++; if (lda.loadReady !== 1'b1 || fsA !== 1'b0) begin errors++; $display("FAIL reset_ready_fs got=%b%b exp=10", lda.loadReady, fsA); end
    end
    resetN = 1'b1;
    tick();
    checks++; if (fsA !== 1'b1 || fsB !== 1'b1) begin errors++; $display("FAIL reset_first_fs got=%b/%b exp=1", fsA, fsB); end
    checks++; if (eA !== m_en || dA !== m_data) begin errors++; $display("FAIL reset_first_out got=%b/%h exp=%b/%h", eA, dA, m_en, m_data); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) tick();
    checks++; if (dA !== m_data) begin errors++; $display("FAIL midrst_before got=%h exp=%h", dA, m_data); end
    #7 resetN = 1'b0;
    #1;
    checks++; if (eA !== 4'b0 || dA !== 8'h00 || dB !== 8'hFF) begin errors++; $display("FAIL midrst_immediate got=%b/%h/%h exp=0000/00/ff", eA, dA, dB); end
    checks++; if (lda.loadReady !== 1'b1 || fsA !== 1'b0) begin errors++; $display("FAIL midrst_ready_fs got=%b%b exp=10", lda.loadReady, fsA); end
    model_reset(); ldq.delete(); fire = 1'b0; drive_load('0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (eA !== 4'b0 || dA !== 8'h00 || lda.loadReady !== 1'b1) begin errors++; $display("FAIL midrst_hold got=%b/%h/%b exp=0000/00/1", eA, dA, lda.loadReady); end
    end
    resetN = 1'b1;
    tick();
    checks++; if (fsA !== 1'b1) begin errors++; $display("FAIL midrst_first_fs got=%b exp=1", fsA); end
  endtask

  task automatic test_scan();
    int lit;
    bit ok;
    logic [7:0] exp_c;
    lit = 0;
    ldq.push_back({16'h1234, 4'h0, 4'hF});
    wait_applied(ok);
    checks++; if (!ok) begin errors++; $display("FAIL scan_timeout got=0 exp=1"); end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++; if (eA !== m_en || eB !== m_en) begin errors++; $display("FAIL scan_en t=%0t got=%b/%b exp=%b", $time, eA, eB, m_en); end
      checks++; if (dA !== m_data || dB !== ~m_data) begin errors++; $display("FAIL scan_data t=%0t got=%h/%h exp=%h", $time, dA, dB, m_data); end
      checks++; if (fsA !== m_fs || lda.loadReady !== m_ready) begin errors++; $display("FAIL scan_fs_rdy t=%0t got=%b%b exp=%b%b", $time, fsA, lda.loadReady, m_fs, m_ready); end
      if (eA !== 4'b0) begin
        lit++;
        case (eA)
          4'b0001: exp_c = 8'h66;
          4'b0010: exp_c = 8'h4F;
          4'b0100: exp_c = 8'h5B;
          4'b1000: exp_c = 8'h06;
          default: exp_c = 8'h00;
        endcase
        checks++; if (dA !== exp_c) begin errors++; $display("FAIL scan_digit en=%b got=%h exp=%h", eA, dA, exp_c); end
      end
    end
    checks++; if (lit != 4 * (R - B)) begin errors++; $display("FAIL scan_lit_cycles got=%0d exp=%0d", lit, 4 * (R - B)); end
  endtask

  task automatic test_stall();
    int stalls;
    bit ok;
    logic [7:0] exp_c;
    stalls = 0; ok = 1'b0;
    ldq.push_back({16'h1234, 4'h0, 4'hF});
    ldq.push_back({16'hABCD, 4'h0, 4'hF});
    for (int i = 0; i < 5 * FRAME && !ok; i++) begin
      tick();
      if (lda.loadValid && !lda.loadReady) stalls++;
      checks++; if (eA !== m_en || eB !== m_en) begin errors++; $display("FAIL stall_en t=%0t got=%b/%b exp=%b", $time, eA, eB, m_en); end
      checks++; if (dA !== m_data || dB !== ~m_data) begin errors++; $display("FAIL stall_data t=%0t got=%h/%h exp=%h", $time, dA, dB, m_data); end
      checks++; if (fsA !== m_fs || lda.loadReady !== m_ready || ldb.loadReady !== m_ready) begin errors++; $display("FAIL stall_fs_rdy t=%0t got=%b%b exp=%b%b", $time, fsA, lda.loadReady, m_fs, m_ready); end
      if (fsA && lda.loadReady && !lda.loadValid && ldq.size() == 0) ok = 1'b1;
    end
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=0 exp=1"); end
    checks++; if (stalls == 0) begin errors++; $display("FAIL stall_backpressure got=%0d exp>0", stalls); end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (eA !== 4'b0) begin
        case (eA)
          4'b0001: exp_c = 8'h5E;
          4'b0010: exp_c = 8'h39;
          4'b0100: exp_c = 8'h7C;
          4'b1000: exp_c = 8'h77;
          default: exp_c = 8'h00;
        endcase
        checks++; if (dA !== exp_c) begin errors++; $display("FAIL stall_digit en=%b got=%h exp=%h", eA, dA, exp_c); end
      end
    end
  endtask

  task automatic test_mask_dp();
    bit ok;
    int seen0;
    seen0 = 0;
    ldq.push_back({16'h0004, 4'b0001, 4'b0101});
    wait_applied(ok);
    checks++; if (!ok) begin errors++; $display("FAIL mask_timeout got=0 exp=1"); end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++; if (eA !== m_en || dA !== m_data) begin errors++; $display("FAIL mask_model t=%0t got=%b/%h exp=%b/%h", $time, eA, dA, m_en, m_data); end
      checks++; if (eA[1] !== 1'b0 || eA[3] !== 1'b0) begin errors++; $display("FAIL mask_dark en got=%b exp=0x0x", eA); end
      if (eA === 4'b0001) begin
        seen0++;
        checks++; if (dA !== 8'hE6) begin errors++; $display("FAIL mask_digit0 got=%h exp=e6", dA); end
      end
      if (eA === 4'b0100) begin
        checks++; if (dA !== 8'h3F) begin errors++; $display("FAIL mask_digit2 got=%h exp=3f", dA); end
      end
    end
    checks++; if (seen0 != R - B) begin errors++; $display("FAIL mask_digit0_cycles got=%0d exp=%0d", seen0, R - B); end
  endtask

  task automatic test_active_low();
    bit ok;
    ldq.push_back({16'h0008, 4'b0000, 4'b0001});
    wait_applied(ok);
    checks++; if (!ok) begin errors++; $display("FAIL actlow_timeout got=0 exp=1"); end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++; if (eB !== m_en || dB !== ~m_data) begin errors++; $display("FAIL actlow_model t=%0t got=%b/%h exp=%b/%h", $time, eB, dB, m_en, ~m_data); end
      if (eB === 4'b0001) begin
        checks++; if (dB !== 8'h80) begin errors++; $display("FAIL actlow_digit0 got=%h exp=80", dB); end
      end
      if (dA === 8'h00) begin
        checks++; if (dB !== 8'hFF || eB !== 4'b0) begin errors++; $display("FAIL actlow_blank got=%h/%b exp=ff/0000", dB, eB); end
      end
    end
  endtask

  task automatic test_boundary_load();
    bit found;
    logic [7:0] exp_c;
    found = 1'b0;
    for (int i = 0; i < 3 * FRAME && !found; i++) begin
      tick();
      if ((m_t % FRAME) == FRAME - 2 && lda.loadReady && !lda.loadValid) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL bnd_sync got=0 exp=1"); end
    ldq.push_back({16'hBEEF, 4'b1010, 4'hF});
    tick();
    checks++; if (lda.loadReady !== m_ready || lda.loadReady !== 1'b1) begin errors++; $display("FAIL bnd_ready_before got=%b exp=1", lda.loadReady); end
    tick();
    checks++; if (fsA !== 1'b1 || lda.loadReady !== 1'b0) begin errors++; $display("FAIL bnd_fs_accept got=%b%b exp=10", fsA, lda.loadReady); end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++; if (eA !== m_en || dA !== m_data || fsA !== m_fs) begin errors++; $display("FAIL bnd_old_frame t=%0t got=%b/%h/%b exp=%b/%h/%b", $time, eA, dA, fsA, m_en, m_data, m_fs); end
    end
    checks++; if (fsA !== 1'b1) begin errors++; $display("FAIL bnd_next_fs got=%b exp=1", fsA); end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      checks++; if (eA !== m_en || dA !== m_data) begin errors++; $display("FAIL bnd_new_frame t=%0t got=%b/%h exp=%b/%h", $time, eA, dA, m_en, m_data); end
      if (eA !== 4'b0) begin
        case (eA)
          4'b0001: exp_c = 8'h71;
          4'b0010: exp_c = 8'hF9;
          4'b0100: exp_c = 8'h79;
          4'b1000: exp_c = 8'hFC;
          default: exp_c = 8'h00;
        endcase
        checks++; if (dA !== exp_c) begin errors++; $display("FAIL bnd_digit en=%b got=%h exp=%h", eA, dA, exp_c); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (ldq.size() == 0 && !lda.loadValid && $urandom_range(0, 15) == 0)
        ldq.push_back({16'($urandom), 4'($urandom), 4'($urandom)});
      tick();
      checks++; if (eA !== m_en || eB !== m_en) begin errors++; $display("FAIL rand_en t=%0t got=%b/%b exp=%b", $time, eA, eB, m_en); end
      checks++; if (dA !== m_data || dB !== ~m_data) begin errors++; $display("FAIL rand_data t=%0t got=%h/%h exp=%h", $time, dA, dB, m_data); end
      checks++; if (fsA !== m_fs || fsB !== m_fs || lda.loadReady !== m_ready) begin errors++; $display("FAIL rand_fs_rdy t=%0t got=%b%b exp=%b%b", $time, fsA, lda.loadReady, m_fs, m_ready); end
    end
  endtask

  initial begin
    drive_load('0, 1'b0);
    model_reset();
    test_reset();
    test_mid_reset();
    test_scan();
    test_stall();
    test_mask_dp();
    test_active_low();
    test_boundary_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
